regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Issue-side scoreboard that sequences access to the 32x32 register file, which has a 1-cycle synchronous read and a synchronous write that ignores x0. It tracks destination registers with writes still in flight and holds issue until every source and destination register is safe. Data read in the same cycle as a write to the same register returns the old value, so no bypass is performed. It sits between decode (the issue handshake) and writeback (the clear port).

Parameters:
NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and is never tracked.
ADDR_W, 5, register address width (log2 NUM_REGS).
MAX_INFLIGHT, 4, maximum outstanding register writes.
CNT_W, 3, width of inflight_count (clog2(MAX_INFLIGHT+1)).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
issue_valid  in  1  decode presents an instruction.
issue_ready  out  1  scoreboard accepts the instruction this cycle (combinational).
issue_rs1  in  ADDR_W  source 1 address.
issue_uses_rs1  in  1  instruction reads rs1.
issue_rs2  in  ADDR_W  source 2 address.
issue_uses_rs2  in  1  instruction reads rs2.
issue_rd  in  ADDR_W  destination address.
issue_writes_rd  in  1  instruction writes rd.
wb_valid  in  1  writeback commits a write this cycle (same cycle as register-file write_enable).
wb_rd  in  ADDR_W  writeback destination.
flush  in  1  pipeline flush; discard all pending writes.
busy_mask  out  NUM_REGS  registered busy bit per register; bit 0 is always 0.
inflight_count  out  CNT_W  registered count of set busy bits.
hazard_raw  out  1  combinational: a used source is busy.
hazard_waw  out  1  combinational: rd is busy, or the in-flight limit is reached with a write pending.
err_spurious_wb  out  1  registered 1-cycle pulse: writeback to a non-busy register, or to x0.

Behaviour:
- Reset (reset_n=0, asynchronous): busy_mask=0, inflight_count=0, err_spurious_wb=0. issue_ready is forced 0 while reset_n=0.
- hazard_raw = (issue_uses_rs1 & busy[rs1]) | (issue_uses_rs2 & busy[rs2]). Busy reads of x0 are always 0.
- hazard_waw = issue_writes_rd & rd!=0 & (busy[rd] | inflight_count==MAX_INFLIGHT).
- issue_ready = reset_n & !flush & !hazard_raw & !hazard_waw. It does not depend on issue_valid.
- Accept = issue_valid & issue_ready.
  - On accept with writes_rd and rd!=0: busy[rd] sets at the next edge and count increments.
  - An instruction with rd=0 or writes_rd=0 is accepted without changing state.
- Writeback with wb_valid, wb_rd!=0 and busy[wb_rd]=1: busy[wb_rd] clears at the next edge and count decrements.
- Writeback with wb_valid to a non-busy register or x0: no state change; err_spurious_wb=1 for exactly the next cycle.
- No same-cycle bypass. A writeback clearing register r in cycle N does not lift a hazard on r until cycle N+1, because the busy bits are registered. This matches the register file returning old data on a same-cycle read.
- Simultaneous accept and writeback to different registers: set and clear both happen; count is unchanged.
- Simultaneous accept and writeback to the same register cannot occur, because WAW blocks the accept.
- Flush has highest priority. At the next edge busy_mask=0 and count=0, and any same-cycle writeback is discarded without an error pulse. issue_ready is 0 during the flush cycle.
- inflight_count always equals popcount(busy_mask) and never exceeds MAX_INFLIGHT.
- Reset asserted mid-operation clears all state immediately. The first accept is possible in the first cycle after reset_n rises.

Test Plan:
- Reset, then issue rd=5 writes → busy_mask=0x20 and count=1 next cycle. Issue rs1=5 uses → issue_ready=0 and hazard_raw=1. wb_rd=5 → hazard_raw still 1 in the wb cycle, issue_ready=1 the cycle after.
- Issue rd=3 while wb_rd=7 (busy) in the same cycle → busy[3]=1, busy[7]=0, count unchanged.
- Issue four writes to rd=1..4 → count=4. A fifth write to rd=6 → hazard_waw=1, ready=0. A fifth instruction with writes_rd=0 and sources 8/9 → accepted.
- WAW: rd=10 busy, issue rd=10 → hazard_waw=1. Issue rd=0 with writes_rd=1 → accepted, busy_mask unchanged.
- wb_rd=12 not busy, and separately wb_rd=0 → err_spurious_wb pulses 1 cycle each; busy_mask unchanged.
- Busy 0x0000_0F00: assert flush with a same-cycle wb_rd=8 → ready=0, next cycle busy_mask=0, count=0, no error pulse. Then drop reset_n mid-stream → outputs 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Issue-side scoreboard for a 32x32 register file with a 1-cycle synchronous
// read and a synchronous write that ignores x0. It tracks which destination
// registers still have a write in flight and holds issue until all sources
// and the destination are safe. No bypass is performed.
//
// Ports:
//   clock, reset_n        - rising-edge clock, asynchronous active-low reset
//   issue_*               - decode-side handshake and register operands
//   issue_ready           - combinational accept indication (ignores issue_valid)
//   wb_valid, wb_rd       - writeback commit (clears a busy bit)
//   flush                 - discard all pending writes
//   busy_mask             - registered busy bit per register (bit 0 always 0)
//   inflight_count        - registered popcount of busy_mask
//   hazard_raw/hazard_waw - combinational hazard flags for the presented instruction
//   err_spurious_wb       - 1-cycle pulse for a writeback to a non-busy register or x0
module regfile_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic                issue_uses_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_uses_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_writes_rd,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    inflight_count,
  output logic                hazard_raw,
  output logic                hazard_waw,
  output logic                err_spurious_wb
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic rd_nonzero;
  logic accept;
  logic set_en;
  logic clr_en;

  // Busy bit 0 is never set, so reads of x0 naturally return 0.
  assign rd_nonzero = (issue_rd != '0);

  assign hazard_raw = (issue_uses_rs1 & busy_q[issue_rs1]) |
                      (issue_uses_rs2 & busy_q[issue_rs2]);

  assign hazard_waw = issue_writes_rd & rd_nonzero &
                      (busy_q[issue_rd] | (cnt_q == CNT_W'(MAX_INFLIGHT)));

  assign issue_ready = reset_n & ~flush & ~hazard_raw & ~hazard_waw;

  assign accept = issue_valid & issue_ready;
  assign set_en = accept & issue_writes_rd & rd_nonzero;
  // A clear only counts when the target is genuinely in flight; anything else
  // is reported as spurious and leaves state untouched.
  assign clr_en = wb_valid & (wb_rd != '0) & busy_q[wb_rd];

  // Per-register next state. set and clr can never hit the same register in
  // one cycle because WAW blocks the accept, so their order does not matter.
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
    logic set_hit;
    logic clr_hit;
    assign set_hit    = set_en && (issue_rd == ADDR_W'(gi));
    assign clr_hit    = clr_en && (wb_rd == ADDR_W'(gi));
    assign busy_d[gi] = ~flush & ((busy_q[gi] | set_hit) & ~clr_hit);
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (flush) begin
      // Flush wins: a same-cycle writeback is dropped silently.
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(set_en) - CNT_W'(clr_en);
      err_d = wb_valid & ~clr_en;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask       = busy_q;
  assign inflight_count  = cnt_q;
  assign err_spurious_wb = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard. Inputs change just after the
// falling edge; combinational outputs are checked before the next rising
// edge and registered outputs 1 time unit after it.
module tb_regfile_scoreboard;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic        issue_uses_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_uses_rs2;
  logic [4:0]  issue_rd;
  logic        issue_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [2:0]  inflight_count;
  logic        hazard_raw;
  logic        hazard_waw;
  logic        err_spurious_wb;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs1      (issue_rs1),
    .issue_uses_rs1 (issue_uses_rs1),
    .issue_rs2      (issue_rs2),
    .issue_uses_rs2 (issue_uses_rs2),
    .issue_rd       (issue_rd),
    .issue_writes_rd(issue_writes_rd),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .flush          (flush),
    .busy_mask      (busy_mask),
    .inflight_count (inflight_count),
    .hazard_raw     (hazard_raw),
    .hazard_waw     (hazard_waw),
    .err_spurious_wb(err_spurious_wb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_uses_rs1 = 0; issue_rs2 = 0;
    issue_uses_rs2 = 0; issue_rd = 0; issue_writes_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  // Present an instruction: valid, rs1/rs2 with use flags, rd with write flag.
  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic w);
    issue_valid = 1; issue_rs1 = rs1; issue_uses_rs1 = u1; issue_rs2 = rs2;
    issue_uses_rs2 = u2; issue_rd = rd; issue_writes_rd = w;
  endtask

  // Advance through a rising edge, then back to the falling edge for new stimulus.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic to_neg();
    @(negedge clock); #1;
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    issue(5'd0, 0, 5'd0, 0, 5'd1, 1);
    #2;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", inflight_count); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_spurious_wb); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", issue_ready); end
    tick(); tick();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_hold_busy: got %h want 0", busy_mask); end
    to_neg(); idle(); reset_n = 1; #1;
    $display("reset released");
  endtask

  task automatic test_raw();
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_first_ready: got %b want 1", issue_ready); end
    tick();
    checks++; if (busy_mask !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy5: got %h want 00000020", busy_mask); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL raw_count1: got %0d want 1", inflight_count); end
    to_neg(); idle(); issue(5'd5, 1, 5'd0, 0, 5'd0, 0); #1;
    checks++; if (hazard_raw !== 1'b1) begin errors++; $display("FAIL raw_hazard: got %b want 1", hazard_raw); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_ready: got %b want 0", issue_ready); end
    wb_valid = 1; wb_rd = 5; #1;
    checks++; if (hazard_raw !== 1'b1) begin errors++; $display("FAIL raw_wb_cycle_hazard: got %b want 1", hazard_raw); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle_ready: got %b want 0", issue_ready); end
    tick();
    wb_valid = 0; #1;
    checks++; if (hazard_raw !== 1'b0) begin errors++; $display("FAIL raw_after_wb_hazard: got %b want 0", hazard_raw); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready: got %b want 1", issue_ready); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL raw_after_wb_count: got %0d want 0", inflight_count); end
    to_neg(); idle();
    $display("raw test done busy=%h count=%0d", busy_mask, inflight_count);
  endtask

  task automatic test_simul();
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1); tick();
    to_neg(); idle();
    issue(5'd0, 0, 5'd0, 0, 5'd3, 1); wb_valid = 1; wb_rd = 7; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b want 1", issue_ready); end
    tick();
    checks++; if (busy_mask !== 32'h0000_0008) begin errors++; $display("FAIL simul_busy: got %h want 00000008", busy_mask); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL simul_count: got %0d want 1", inflight_count); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL simul_err: got %b want 0", err_spurious_wb); end
    to_neg(); idle(); wb_valid = 1; wb_rd = 3; tick();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL simul_clear3: got %h want 0", busy_mask); end
    to_neg(); idle();
    $display("simultaneous set/clear test done");
  endtask

  task automatic test_limit();
    for (int r = 1; r <= 4; r++) begin
      issue(5'd0, 0, 5'd0, 0, 5'(r), 1); tick(); to_neg();
    end
    idle();
    checks++; if (inflight_count !== 3'd4) begin errors++; $display("FAIL limit_count4: got %0d want 4", inflight_count); end
    checks++; if (busy_mask !== 32'h0000_001E) begin errors++; $display("FAIL limit_busy: got %h want 0000001e", busy_mask); end
    issue(5'd0, 0, 5'd0, 0, 5'd6, 1); #1;
    checks++; if (hazard_waw !== 1'b1) begin errors++; $display("FAIL limit_waw: got %b want 1", hazard_waw); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL limit_ready: got %b want 0", issue_ready); end
    tick();
    checks++; if (inflight_count !== 3'd4) begin errors++; $display("FAIL limit_blocked_count: got %0d want 4", inflight_count); end
    to_neg(); issue(5'd8, 1, 5'd9, 1, 5'd6, 0); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL limit_nowrite_ready: got %b want 1", issue_ready); end
    checks++; if (hazard_waw !== 1'b0) begin errors++; $display("FAIL limit_nowrite_waw: got %b want 0", hazard_waw); end
    tick();
    checks++; if (busy_mask !== 32'h0000_001E) begin errors++; $display("FAIL limit_nowrite_busy: got %h want 0000001e", busy_mask); end
    to_neg(); issue(5'd0, 0, 5'd0, 0, 5'd0, 1); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL limit_x0_ready: got %b want 1", issue_ready); end
    to_neg(); idle(); flush = 1; tick();
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL limit_flush_count: got %0d want 0", inflight_count); end
    to_neg(); idle();
    $display("inflight limit test done");
  endtask

  task automatic test_waw();
    issue(5'd0, 0, 5'd0, 0, 5'd10, 1); tick();
    to_neg(); issue(5'd0, 0, 5'd0, 0, 5'd10, 1); #1;
    checks++; if (hazard_waw !== 1'b1) begin errors++; $display("FAIL waw_hazard: got %b want 1", hazard_waw); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_ready: got %b want 0", issue_ready); end
    issue(5'd0, 0, 5'd0, 0, 5'd0, 1); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_x0_ready: got %b want 1", issue_ready); end
    tick();
    checks++; if (busy_mask !== 32'h0000_0400) begin errors++; $display("FAIL waw_x0_busy: got %h want 00000400", busy_mask); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL waw_x0_count: got %0d want 1", inflight_count); end
    to_neg(); idle();
    $display("waw test done");
  endtask

  task automatic test_spurious();
    wb_valid = 1; wb_rd = 12; tick();
    checks++; if (err_spurious_wb !== 1'b1) begin errors++; $display("FAIL spur12_err: got %b want 1", err_spurious_wb); end
    checks++; if (busy_mask !== 32'h0000_0400) begin errors++; $display("FAIL spur12_busy: got %h want 00000400", busy_mask); end
    to_neg(); idle(); tick();
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL spur12_pulse_end: got %b want 0", err_spurious_wb); end
    to_neg(); wb_valid = 1; wb_rd = 0; tick();
    checks++; if (err_spurious_wb !== 1'b1) begin errors++; $display("FAIL spur0_err: got %b want 1", err_spurious_wb); end
    checks++; if (inflight_count !== 3'd1) begin errors++; $display("FAIL spur0_count: got %0d want 1", inflight_count); end
    to_neg(); idle(); tick();
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL spur0_pulse_end: got %b want 0", err_spurious_wb); end
    to_neg();
    $display("spurious writeback test done");
  endtask

  task automatic test_flush_and_reset();
    for (int r = 8; r <= 11; r++) begin
      if (r != 10) begin
        issue(5'd0, 0, 5'd0, 0, 5'(r), 1); tick(); to_neg();
      end
    end
    idle();
    checks++; if (busy_mask !== 32'h0000_0F00) begin errors++; $display("FAIL flush_pre_busy: got %h want 00000f00", busy_mask); end
    issue(5'd0, 0, 5'd0, 0, 5'd0, 0); flush = 1; wb_valid = 1; wb_rd = 8; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", issue_ready); end
    tick();
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL flush_busy: got %h want 0", busy_mask); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", inflight_count); end
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", err_spurious_wb); end
    to_neg(); idle();
    issue(5'd0, 0, 5'd0, 0, 5'd2, 1); tick();
    checks++; if (busy_mask !== 32'h0000_0004) begin errors++; $display("FAIL midrst_pre_busy: got %h want 00000004", busy_mask); end
    idle(); wb_valid = 1; wb_rd = 4; #2;
    reset_n = 0; #1;
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL midrst_busy: got %h want 0", busy_mask); end
    checks++; if (inflight_count !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", inflight_count); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", issue_ready); end
    tick();
    checks++; if (err_spurious_wb !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err_spurious_wb); end
    to_neg(); idle(); reset_n = 1;
    issue(5'd0, 0, 5'd0, 0, 5'd2, 1); #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready: got %b want 1", issue_ready); end
    tick();
    checks++; if (busy_mask !== 32'h0000_0004) begin errors++; $display("FAIL postrst_busy: got %h want 00000004", busy_mask); end
    to_neg(); idle();
    $display("flush and mid-stream reset test done");
  endtask

  initial begin
    test_reset();
    test_raw();
    test_simul();
    test_limit();
    test_waw();
    test_spurious();
    test_flush_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
